inst_loader: RTL
================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256, maximum number of instruction words accepted per load.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  host byte stream valid.
REQ-005 in_data  input  8  host byte.
REQ-006 in_ready  output  1  loader can accept a byte this cycle.
REQ-007 load_req  input  1  one-cycle pulse; from RUN, restarts a new load.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  32  byte address of the word being written.
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 cpu_start  output  1  CPU run enable; low holds the CPU in reset.
REQ-012 words_loaded  output  16  count of words written in the current load.
REQ-013 err  output  1  header length exceeded MAX_WORDS.

Function
REQ-014 A byte transfers only on a cycle with in_valid=1 and in_ready=1.
REQ-015 The state machine SHALL have states HDR_LO, HDR_HI, DATA, RUN and ERR.
REQ-016 in_ready = 1 in HDR_LO, HDR_HI and DATA; 0 in RUN and ERR.
REQ-017 HDR_LO: the accepted byte becomes N[7:0]; go to HDR_HI.
REQ-018 HDR_HI: the accepted byte becomes N[15:8].
REQ-019 HDR_HI exit: N=0 -> RUN; N>MAX_WORDS -> ERR; otherwise -> DATA.
REQ-020 DATA: bytes are assembled little-endian; the first byte of a word goes to bits [7:0] and the fourth to bits [31:24].
REQ-021 A 2-bit byte counter wraps 3->0 on the fourth accepted byte of each word.
REQ-022 On the cycle after the fourth byte is accepted, imem_we=1 for exactly one cycle.
REQ-023 During that write cycle, imem_wdata holds the assembled word and imem_addr = 4*k, where k is the 0-based word index.
REQ-024 words_loaded increments in the same cycle as each imem_we pulse.
REQ-025 When words_loaded reaches N, go to RUN; cpu_start rises on the cycle after the last imem_we, never in the same cycle.
REQ-026 cpu_start = 1 only in RUN; it stays high until rst or load_req.
REQ-027 load_req in RUN: on the next edge, cpu_start=0, words_loaded=0, byte counter=0, state=HDR_LO.
REQ-028 load_req is ignored in every state other than RUN.
REQ-029 ERR: err=1, cpu_start=0, imem_we=0; leave ERR only via rst.
REQ-030 in_valid gaps (bubbles) anywhere in the header or data SHALL stall assembly with no effect on counters or outputs.
REQ-031 imem_addr and imem_wdata are don't-care when imem_we=0, but must hold their last written values, not be X.

Reset
REQ-032 On rst=1 at a clock edge, the block enters HDR_LO.
REQ-033 On that edge, every output resets to 0 except in_ready, which is 1.
REQ-034 On that edge, byte counter, N and the word index are cleared.
REQ-035 rst in the middle of a word or header discards partial bytes; no imem_we is issued for a partial word.
REQ-036 rst has priority over load_req and over any byte transfer in the same cycle.

Structure
REQ-037 The state enum, MAX_WORDS default and the header byte count (2) belong in the shared CPU package.
REQ-038 One sub-module, byte_packer, holds the byte counter and the 32-bit shift/assembly register, and emits a word_done pulse.
REQ-039 The top level holds the FSM, word index and outputs.
REQ-040 cpu_start connects to the CPU start input; imem_* connect to the instruction-memory write port.

Verification
REQ-041 Header 0x02,0x00 then bytes 13 05 50 00 / 93 05 10 00 -> writes 0x00500513@0 and 0x00100593@4; cpu_start=1 one cycle after the second imem_we; words_loaded=2.
REQ-042 Header 0x00,0x00 -> RUN directly after HDR_HI; no imem_we; cpu_start=1.
REQ-043 Header 0x01,0x01 (N=257, MAX_WORDS=256) -> err=1, in_ready=0, cpu_start=0; stays in ERR until rst.
REQ-044 N=1 with in_valid toggling 1,0,0,1,1,0,1 -> exactly one imem_we, carrying the correct word; no extra writes.
REQ-045 rst after 2 data bytes of word 1 -> no imem_we; restart with a full load gives a correct word at address 0.
REQ-046 In RUN, pulse load_req and load N=1 word 0xDEADBEEF -> cpu_start drops next cycle and rises again after the write to address 0; words_loaded=1.

Source files
------------

// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader_pkg
//  Description : Shared constants and the loader state type used by the
//                instruction loader and its byte packer.
//                Contents: c_max_words_default (default word limit per load),
//                c_hdr_bytes (length-header size in bytes), c_word_bytes
//                (bytes per instruction word), state_t (loader states).
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_loader_pkg;

    localparam int unsigned c_max_words_default = 256;
    localparam int unsigned c_hdr_bytes         = 2;
    localparam int unsigned c_word_bytes        = 4;

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DATA   = 3'd2,
        RUN    = 3'd3,
        ERR    = 3'd4
    } state_t;

endpackage : inst_loader_pkg
`default_nettype wire

// File: rtl/inst_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader_if
//  Description : Host byte stream, instruction-memory write port and CPU
//                control signals of the instruction loader.
//                master : host side  (drives in_valid, in_data, load_req)
//                slave  : loader side (drives in_ready, imem_we, imem_addr,
//                         imem_wdata, cpu_start, words_loaded, err)
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_loader_if;

    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        load_req;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_start;
    logic [15:0] words_loaded;
    logic        err;

    modport master (
        output in_valid, in_data, load_req,
        input  in_ready, imem_we, imem_addr, imem_wdata,
               cpu_start, words_loaded, err
    );

    modport slave (
        input  in_valid, in_data, load_req,
        output in_ready, imem_we, imem_addr, imem_wdata,
               cpu_start, words_loaded, err
    );

endinterface : inst_loader_if
`default_nettype wire

// File: rtl/inst_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader_byte_packer
//  Description : Packs accepted bytes little-endian into 32-bit words.
//                clk, rst      : clock, synchronous active-high reset
//                i_clr         : discard any partial word (held while the
//                                loader is not receiving data)
//                i_byte_valid  : a data byte is accepted this cycle
//                i_byte        : the data byte
//                o_last_byte   : the next accepted byte completes a word
//                o_word        : last completed word (held between words)
//                o_word_done   : one-cycle pulse, the cycle after completion
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_loader_byte_packer
    import inst_loader_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_clr,
    input  wire logic        i_byte_valid,
    input  wire logic [7:0]  i_byte,
    output logic             o_last_byte,
    output logic [31:0]      o_word,
    output logic             o_word_done
);

    localparam logic [1:0] c_last_cnt = 2'(c_word_bytes - 1);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_done;

    assign o_last_byte = (r_cnt == c_last_cnt);
    assign o_word      = r_word;
    assign o_word_done = r_word_done;

    // Bytes enter at the top and move down, so after three bytes the first
    // one sits in [7:0]; the fourth byte is placed directly into [31:24].
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt       <= 2'd0;
            r_shift     <= 24'd0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (i_byte_valid) begin
                r_cnt   <= r_cnt + 2'd1;   // natural wrap 3 -> 0
                r_shift <= {i_byte, r_shift[23:8]};
                if (r_cnt == c_last_cnt) begin
                    r_word_done <= 1'b1;
                end
            end
        end
    end

    // The completed word is held until the next one so the write data never
    // floats between strobes; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= 32'd0;
        end else if (!i_clr && i_byte_valid && (r_cnt == c_last_cnt)) begin
            r_word <= {i_byte, r_shift};
        end
    end

endmodule : inst_loader_byte_packer
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader
//  Description : Receives a 2-byte little-endian word count followed by
//                little-endian instruction words, writes them to instruction
//                memory at consecutive word addresses, then releases the CPU.
//                clk, rst : clock, synchronous active-high reset
//                bus      : inst_loader_if.slave (host stream in, imem write
//                           port, cpu_start, words_loaded, err out)
//                MAX_WORDS: largest word count accepted in a header
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = c_max_words_default
)(
    input  wire logic     clk,
    input  wire logic     rst,
    inst_loader_if.slave  bus
);

    localparam int unsigned c_len_w = 8 * c_hdr_bytes;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_len_w-1:0] r_hdr_len;
    logic [c_len_w-1:0] w_hdr_len_full;
    logic [15:0]        r_words_loaded;
    logic [31:0]        r_imem_addr;
    logic               w_in_ready;
    logic               w_byte_acc;
    logic               w_data_acc;
    logic               w_last_byte;
    logic               w_word_done;
    logic [31:0]        w_word;

    assign w_byte_acc     = bus.in_valid && w_in_ready;
    assign w_data_acc     = w_byte_acc && (r_state == DATA);
    // Full count as it will be once the high header byte is taken.
    assign w_hdr_len_full = {bus.in_data, r_hdr_len[7:0]};

    inst_loader_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (r_state != DATA),
        .i_byte_valid (w_data_acc),
        .i_byte       (bus.in_data),
        .o_last_byte  (w_last_byte),
        .o_word       (w_word),
        .o_word_done  (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HDR_LO;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_in_ready    = 1'b0;
        bus.cpu_start = 1'b0;
        bus.err       = 1'b0;
        case (r_state)
            HDR_LO: begin
                w_in_ready = 1'b1;
                if (w_byte_acc) begin
                    w_state_nxt = HDR_HI;
                end
            end
            HDR_HI: begin
                w_in_ready = 1'b1;
                if (w_byte_acc) begin
                    if (w_hdr_len_full == '0) begin
                        w_state_nxt = RUN;
                    end else if (32'(w_hdr_len_full) > MAX_WORDS) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                w_in_ready = 1'b1;
                // words_loaded already shows the new count during the write
                // strobe, so the final strobe is where the load completes.
                if (w_word_done && (r_words_loaded == r_hdr_len)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                bus.cpu_start = 1'b1;
                if (bus.load_req) begin
                    w_state_nxt = HDR_LO;
                end
            end
            ERR: begin
                bus.err = 1'b1;
            end
            default: begin
                w_state_nxt = HDR_LO;
            end
        endcase
    end

    // Header capture, word index and write address. The address and count
    // are updated on the edge that completes a word, so both line up with
    // the write strobe the packer raises on that same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_len      <= '0;
            r_words_loaded <= 16'd0;
            r_imem_addr    <= 32'd0;
        end else begin
            if ((r_state == HDR_LO) && w_byte_acc) begin
                r_hdr_len[7:0] <= bus.in_data;
            end
            if ((r_state == HDR_HI) && w_byte_acc) begin
                r_hdr_len[15:8] <= bus.in_data;
            end
            if ((r_state == RUN) && bus.load_req) begin
                r_words_loaded <= 16'd0;
            end else if (w_data_acc && w_last_byte) begin
                r_words_loaded <= r_words_loaded + 16'd1;
                r_imem_addr    <= {14'd0, r_words_loaded, 2'b00};
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.imem_we      = w_word_done;
    assign bus.imem_addr    = r_imem_addr;
    assign bus.imem_wdata   = w_word;
    assign bus.words_loaded = r_words_loaded;

endmodule : inst_loader
`default_nettype wire
